// File: rtl/branch_predictor_unit.sv
// Gshare direction predictor with a direct-mapped BTB and speculative global history.
// Define BPU_TAG_CHECK_EN to store BTB tags so that aliasing PCs miss.
module branch_predictor_unit #(
   parameter int unsigned PC_W     = 32,
   parameter int unsigned IDX_W    = 5,
   parameter int unsigned GHR_W    = 4,
   parameter logic [1:0]  CTR_INIT = 2'b01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             f_valid,
   input  logic [PC_W-1:0]  f_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pred_target,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             upd_valid,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_is_branch,
   input  logic             upd_taken,
   input  logic [PC_W-1:0]  upd_target,
   input  logic             upd_mispredict
);

   localparam int unsigned Entries = 2 ** IDX_W;
   localparam int unsigned TagW    = PC_W - IDX_W;

   logic [Entries-1:0] btb_valid_q;
   logic [PC_W-1:0]    btb_target_q [Entries];
   logic [1:0]         pht_q        [Entries];
   logic [GHR_W-1:0]   ghr_q, ghr_d;

   logic [IDX_W-1:0] f_btb_idx, f_pht_idx;
   logic [IDX_W-1:0] upd_btb_idx, upd_pht_idx;
   logic             f_tag_hit;
   logic             train_en;
   logic [1:0]       pht_upd_d;
   logic [GHR_W-1:0] ghr_spec, ghr_rec;

   assign f_btb_idx   = f_pc[IDX_W-1:0];
   assign f_pht_idx   = f_btb_idx ^ IDX_W'(ghr_q);
   assign upd_btb_idx = upd_pc[IDX_W-1:0];
   assign upd_pht_idx = upd_btb_idx ^ IDX_W'(upd_ghr);
   assign train_en    = upd_valid & upd_is_branch;

`ifdef BPU_TAG_CHECK_EN
   logic [TagW-1:0] btb_tag_q [Entries];

   assign f_tag_hit = (btb_tag_q[f_btb_idx] == f_pc[PC_W-1:IDX_W]);

   always_ff @(posedge clk) begin
      if (!reset && train_en && upd_taken) begin
         btb_tag_q[upd_btb_idx] <= upd_pc[PC_W-1:IDX_W];
      end
   end
`else
   logic unused_tag_bits;

   assign f_tag_hit       = 1'b1;
   assign unused_tag_bits = ^{f_pc[PC_W-1:IDX_W], upd_pc[PC_W-1:IDX_W]};
`endif

   // Lookup is purely combinational; same-cycle writes are seen only after the edge.
   always_comb begin
      pred_hit    = btb_valid_q[f_btb_idx] & f_tag_hit;
      pred_taken  = pred_hit & pht_q[f_pht_idx][1];
      pred_target = pred_taken ? btb_target_q[f_btb_idx] : f_pc + PC_W'(1);
      pred_ghr    = ghr_q;
   end

   if (GHR_W == 1) begin : g_ghr_one
      assign ghr_spec = pred_taken;
      assign ghr_rec  = upd_taken;
   end else begin : g_ghr_multi
      assign ghr_spec = {ghr_q[GHR_W-2:0], pred_taken};
      assign ghr_rec  = {upd_ghr[GHR_W-2:0], upd_taken};
   end

   // Recovery from execute wins over the fetch-side speculative shift.
   always_comb begin
      ghr_d = ghr_q;
      if (upd_valid && upd_mispredict) begin
         ghr_d = ghr_rec;
      end else if (f_valid && pred_hit) begin
         ghr_d = ghr_spec;
      end
   end

   always_comb begin
      pht_upd_d = pht_q[upd_pht_idx];
      if (upd_taken) begin
         if (pht_upd_d != 2'b11) pht_upd_d = pht_upd_d + 2'b01;
      end else begin
         if (pht_upd_d != 2'b00) pht_upd_d = pht_upd_d - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btb_valid_q <= '0;
         ghr_q       <= '0;
         for (int i = 0; i < Entries; i++) begin
            pht_q[i] <= CTR_INIT;
         end
      end else begin
         ghr_q <= ghr_d;
         if (train_en) begin
            pht_q[upd_pht_idx] <= pht_upd_d;
            if (upd_taken) begin
               btb_valid_q[upd_btb_idx]  <= 1'b1;
               btb_target_q[upd_btb_idx] <= upd_target;
            end
         end
      end
   end

endmodule

// File: doc/branch_predictor_unit.md
# branch_predictor_unit

Parametrised gshare direction predictor plus branch target buffer for the fetch stage. Performs a same-cycle lookup on the fetch PC and returns a taken/not-taken prediction, a BTB hit and a next-PC. Keeps a speculative global history register (GHR) with rollback on mispredict. Trains its counters and BTB from execute-stage resolution.

## Interface

Parameters:
- `PC_W`, 32, PC width (word-addressed; sequential next PC is PC+1)
- `IDX_W`, 5, BTB/PHT index bits; both tables have 2^IDX_W entries
- `GHR_W`, 4, history length; legal range 1 ≤ GHR_W ≤ IDX_W
- `CTR_INIT`, 2'b01, reset value of every 2-bit PHT counter

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `f_valid` in 1: fetch lookup is real and may advance the GHR
- `f_pc` in PC_W: fetch PC
- `pred_hit` out 1: BTB hit for `f_pc`
- `pred_taken` out 1: predicted taken
- `pred_target` out PC_W: next PC
- `pred_ghr` out GHR_W: GHR used for this lookup; piped to execute
- `upd_valid` in 1: resolution valid this cycle
- `upd_pc` in PC_W: resolved instruction PC
- `upd_ghr` in GHR_W: `pred_ghr` snapshot carried with the instruction
- `upd_is_branch` in 1: resolved instruction is a conditional branch
- `upd_taken` in 1: actual direction
- `upd_target` in PC_W: actual taken target
- `upd_mispredict` in 1: direction or target was mispredicted

## Operation

- **Storage.** Flop arrays, with no memory macro:
  - BTB: valid, target[PC_W], and tag[PC_W-IDX_W] when tag checking is enabled
  - PHT: 2-bit saturating counters
  - GHR register
- **Lookup (combinational).**
  - BTB index = `f_pc[IDX_W-1:0]`.
  - PHT index = `f_pc[IDX_W-1:0] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}`.
  - `pred_hit` = valid (and tag match when enabled).
  - `pred_taken` = `pred_hit & pht[idx][1]`.
  - `pred_target` = `btb.target` if `pred_taken`, else `f_pc+1` (truncated to PC_W; wraps at max PC).
  - `pred_ghr` = current GHR.
- **Speculative history.** When `f_valid & pred_hit`: GHR <= `{ghr[GHR_W-2:0], pred_taken}`. For GHR_W=1 this is GHR <= `pred_taken`.
- **Training.** Only when `upd_valid & upd_is_branch`; all other updates are ignored.
  - PHT entry at `upd_pc[IDX_W-1:0] ^ upd_ghr` increments on `upd_taken`, otherwise decrements. Saturates at 2'b11 and 2'b00.
  - On `upd_taken`: BTB entry at `upd_pc[IDX_W-1:0]` <= valid=1, target=`upd_target`, tag=`upd_pc[PC_W-1:IDX_W]`.
  - A not-taken branch leaves the BTB unchanged.
- **Recovery.** When `upd_valid & upd_mispredict`: GHR <= `{upd_ghr[GHR_W-2:0], upd_taken}`.
- **Simultaneous events.**
  - Recovery overrides the speculative shift in the same cycle.
  - A same-cycle update and lookup to the same entry: the lookup sees the pre-update contents.
- **Reset.** Applies to every entry on the next rising edge, including mid-operation:
  - all BTB valid = 0
  - all counters = CTR_INIT
  - GHR = 0
- **Reset output values.** With `f_pc=P`: `pred_hit=0`, `pred_taken=0`, `pred_target=P+1`, `pred_ghr=0`.

## Timing

- Lookup latency is 0 cycles: outputs are combinational from `f_pc` and state.
- Updates, GHR shifts and recovery are registered and become visible on the cycle after the edge.
- There is no handshake; `upd_valid` is a one-cycle strobe, and one update is accepted per cycle.
- `f_valid=0` (stall or bubble) freezes the GHR; the outputs stay driven.
- Critical path is BTB read → tag compare → `pred_target` mux. The block must close at the fetch-stage clock with IDX_W ≤ 8.

## Configuration

- Macro: `BPU_TAG_CHECK_EN`.
- **Defined:**
  - The BTB stores `upd_pc[PC_W-1:IDX_W]`.
  - `pred_hit` requires valid and a tag match, so aliasing PCs miss.
- **Undefined:**
  - No tag storage.
  - `pred_hit` = valid only, so aliasing PCs share an entry and hit.

## Test plan

Default parameters (IDX_W=5, GHR_W=4):

1. **Reset state.** Reset, then lookup `f_pc=3`, `f_valid=0` -> `pred_hit=0`, `pred_taken=0`, `pred_target=4`, `pred_ghr=0`.
2. **Train taken.** Update pc=3, ghr=0, branch, taken, target=0x14, no mispredict. Next cycle lookup pc=3 -> `pred_hit=1`, `pred_taken=1` (counter 01→10), `pred_target=0x14`, GHR unchanged at 0.
3. **Saturation.** Four taken updates at pc=3/ghr=0 -> counter 11. One not-taken update -> counter 10, still `pred_taken=1`. Three further not-taken updates -> 00; a fifth -> stays 00, `pred_taken=0`, `pred_target=4`.
4. **Speculative shift vs. recovery.**
   - With GHR=0 and a hitting taken lookup with `f_valid=1` -> GHR=4'b0001 next cycle.
   - In the same cycle as a hitting `f_valid` lookup, apply a mispredict with `upd_ghr=4'b0101`, `upd_taken=0` -> GHR=4'b1010, not the shifted value.
5. **Aliasing.** After training pc=0x03 taken->0x14, look up pc=0x23 -> `pred_hit=0`, `pred_target=0x24` with `BPU_TAG_CHECK_EN`; `pred_hit=1` (counter permitting `pred_target=0x14`) without it.
6. **Reset mid-operation.** After scenarios 2–4, assert reset for one cycle while `upd_valid=1` -> update discarded. Lookup pc=3 -> `pred_hit=0`, `pred_ghr=0`, counters read CTR_INIT.
